// File: rtl/stream_intf_pkg.sv
// Shared stream-interface constants for the DMA-to-Mage bridge.
// Holds the channel count, word width, per-channel FIFO depth and the
// number of consecutive stalled DMA cycles that marks an overflow.
package stream_intf_pkg;

  localparam int N_DMA_CH          = 4;
  localparam int STREAM_DATA_W     = 32;
  localparam int STREAM_FIFO_DEPTH = 8;
  localparam int OVF_CYC           = 16;

endpackage

// File: rtl/mage_stream_fifo.sv
// Single-channel elastic buffer between one DMA write stream and one Mage
// stream input.
// Ports:
//   clk_i, rst_n_i             clock, async active-low reset
//   dma_valid_i/dma_data_i     DMA word in; dma_ready_o accepts it
//   mage_valid_o/mage_data_o   head word out; mage_ready_i consumes it
//   flush_i                    synchronous clear of pointers and count
//   count_o, almost_full_o     occupancy and almost-full flag
//   overflow_o, clr_status_i   sticky long-stall flag and its clear
module mage_stream_fifo
  import stream_intf_pkg::*;
#(
  parameter int DATA_W    = STREAM_DATA_W,
  parameter int DEPTH     = STREAM_FIFO_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int OVF_LIMIT = OVF_CYC
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       dma_valid_i,
  input  logic [DATA_W-1:0]          dma_data_i,
  output logic                       dma_ready_o,
  output logic                       mage_valid_o,
  output logic [DATA_W-1:0]          mage_data_o,
  input  logic                       mage_ready_i,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       almost_full_o,
  output logic                       overflow_o,
  input  logic                       clr_status_i
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int STALL_W = $clog2(OVF_LIMIT + 1);

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [STALL_W-1:0] stall_cnt;
  logic               push;
  logic               pop;
  logic               stall;
  logic               ovf_set;

  // All flags derive from the registered count, so ready never depends
  // combinationally on the Mage side and a pop at full cannot admit a
  // same-cycle push.
  assign dma_ready_o   = (count != CNT_W'(DEPTH));
  assign mage_valid_o  = (count != '0);
  assign mage_data_o   = mage_valid_o ? mem[rd_ptr] : '0;
  assign count_o       = count;
  assign almost_full_o = (count >= CNT_W'(AF_THRESH));

  assign push  = dma_valid_i & dma_ready_o;
  assign pop   = mage_valid_o & mage_ready_i;
  assign stall = dma_valid_i & ~dma_ready_o;
  // True in the stall cycle that brings the run length up to the limit.
  assign ovf_set = stall & (stall_cnt >= STALL_W'(OVF_LIMIT - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Storage is deliberately left unreset; the output gate hides stale data.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) mem[wr_ptr] <= dma_data_i;
  end

  // Overflow monitor is independent of flush.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt  <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (!stall)
        stall_cnt <= '0;
      else if (stall_cnt != STALL_W'(OVF_LIMIT))
        stall_cnt <= stall_cnt + STALL_W'(1);

      if (ovf_set)           overflow_o <= 1'b1;
      else if (clr_status_i) overflow_o <= 1'b0;
    end
  end

endmodule

// File: rtl/mage_stream_fifo_bridge.sv
// Per-channel elastic buffer bank between the DMA write channels and the
// Mage hardware-FIFO stream inputs; one mage_stream_fifo per channel.
// Ports (all per channel, indexed [N_CH]):
//   dma_valid_i/dma_data_i/dma_ready_o      DMA-side stream
//   mage_valid_o/mage_data_o/mage_ready_i   Mage-side stream
//   flush_i, count_o, almost_full_o         control and occupancy
//   overflow_o, clr_status_i                sticky stall status
module mage_stream_fifo_bridge
  import stream_intf_pkg::*;
#(
  parameter int N_CH      = N_DMA_CH,
  parameter int DATA_W    = STREAM_DATA_W,
  parameter int DEPTH     = STREAM_FIFO_DEPTH,
  parameter int AF_THRESH = DEPTH - 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_n_i,
  input  logic [N_CH-1:0]                       dma_valid_i,
  input  logic [N_CH-1:0][DATA_W-1:0]           dma_data_i,
  output logic [N_CH-1:0]                       dma_ready_o,
  output logic [N_CH-1:0]                       mage_valid_o,
  output logic [N_CH-1:0][DATA_W-1:0]           mage_data_o,
  input  logic [N_CH-1:0]                       mage_ready_i,
  input  logic [N_CH-1:0]                       flush_i,
  output logic [N_CH-1:0][$clog2(DEPTH+1)-1:0]  count_o,
  output logic [N_CH-1:0]                       almost_full_o,
  output logic [N_CH-1:0]                       overflow_o,
  input  logic [N_CH-1:0]                       clr_status_i
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    mage_stream_fifo #(
      .DATA_W    (DATA_W),
      .DEPTH     (DEPTH),
      .AF_THRESH (AF_THRESH)
    ) u_fifo (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .dma_valid_i   (dma_valid_i[g]),
      .dma_data_i    (dma_data_i[g]),
      .dma_ready_o   (dma_ready_o[g]),
      .mage_valid_o  (mage_valid_o[g]),
      .mage_data_o   (mage_data_o[g]),
      .mage_ready_i  (mage_ready_i[g]),
      .flush_i       (flush_i[g]),
      .count_o       (count_o[g]),
      .almost_full_o (almost_full_o[g]),
      .overflow_o    (overflow_o[g]),
      .clr_status_i  (clr_status_i[g])
    );
  end

endmodule

// File: tb/tb_mage_stream_fifo_bridge.sv
// Bench for mage_stream_fifo_bridge: directed scenarios plus randomized
// traffic, checked every cycle against a queue-based channel model.
module tb_mage_stream_fifo_bridge;

  localparam int N_CH  = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int OVF   = 16;
  localparam int CW    = 4;

  logic                      clk;
  logic                      rst_n;
  logic [N_CH-1:0]           dma_valid;
  logic [N_CH-1:0][DW-1:0]   dma_data;
  logic [N_CH-1:0]           dma_ready;
  logic [N_CH-1:0]           mage_valid;
  logic [N_CH-1:0][DW-1:0]   mage_data;
  logic [N_CH-1:0]           mage_ready;
  logic [N_CH-1:0]           flush;
  logic [N_CH-1:0][CW-1:0]   count;
  logic [N_CH-1:0]           almost_full;
  logic [N_CH-1:0]           overflow;
  logic [N_CH-1:0]           clr_status;

  mage_stream_fifo_bridge dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .dma_valid_i   (dma_valid),
    .dma_data_i    (dma_data),
    .dma_ready_o   (dma_ready),
    .mage_valid_o  (mage_valid),
    .mage_data_o   (mage_data),
    .mage_ready_i  (mage_ready),
    .flush_i       (flush),
    .count_o       (count),
    .almost_full_o (almost_full),
    .overflow_o    (overflow),
    .clr_status_i  (clr_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model: one word queue per channel, stall run length, flag.
  logic [DW-1:0] q [N_CH][$];
  int            run  [N_CH];
  bit            ovf  [N_CH];
  bit            held [N_CH];

  task automatic chk(input string nm, input int ch, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s ch%0d at %0t: got %0h, expected %0h", nm, ch, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      q[c].delete();
      run[c]  = 0;
      ovf[c]  = 1'b0;
      held[c] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < N_CH; c++) begin
      int sz  = q[c].size();
      bit rdy = (sz != DEPTH);
      bit psh = dma_valid[c] && rdy;
      bit pp  = (sz != 0) && mage_ready[c];
      bit stl = dma_valid[c] && !rdy;
      held[c] = stl;
      if (flush[c]) q[c].delete();
      else begin
        if (pp)  void'(q[c].pop_front());
        if (psh) q[c].push_back(dma_data[c]);
      end
      run[c] = stl ? ((run[c] < OVF) ? run[c] + 1 : OVF) : 0;
      if (run[c] == OVF)  ovf[c] = 1'b1;
      else if (clr_status[c]) ovf[c] = 1'b0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  task automatic compare_all();
    for (int c = 0; c < N_CH; c++) begin
      int sz = q[c].size();
      logic [DW-1:0] head = '0;
      if (sz != 0) head = q[c][0];
      chk("count", c, count[c], sz);
      chk("mage_valid", c, mage_valid[c], (sz != 0));
      chk("mage_data", c, mage_data[c], head);
      chk("dma_ready", c, dma_ready[c], (sz != DEPTH));
      chk("almost_full", c, almost_full[c], (sz >= AF));
      chk("overflow", c, overflow[c], ovf[c]);
    end
  endtask

  always @(negedge clk) if (chk_en) compare_all();

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int c = 0; c < N_CH; c++) begin
      chk({tag, "_count"}, c, count[c], 0);
      chk({tag, "_ready"}, c, dma_ready[c], 1);
      chk({tag, "_valid"}, c, mage_valid[c], 0);
      chk({tag, "_data"}, c, mage_data[c], 0);
      chk({tag, "_af"}, c, almost_full[c], 0);
      chk({tag, "_ovf"}, c, overflow[c], 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    dma_valid = '0; dma_data = '0; mage_ready = '0; flush = '0; clr_status = '0;
    #1;
    chk_reset_vals("rst");
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Basic transfer on ch0
    for (int i = 0; i < 8; i++) begin
      dma_valid[0] = 1'b1;
      dma_data[0]  = DW'(32'hA0 + i);
      tick();
      chk("t1_count", 0, count[0], i + 1);
      chk("t1_af", 0, almost_full[0], (i + 1 >= 6));
    end
    dma_valid[0] = 1'b0;
    chk("t1_ready_full", 0, dma_ready[0], 0);
    mage_ready[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t1_out", 0, mage_data[0], 32'hA0 + i);
      tick();
    end
    chk("t1_empty", 0, count[0], 0);
    mage_ready[0] = 1'b0;

    // Streaming on ch1
    mage_ready[1] = 1'b1;
    dma_valid[1]  = 1'b1;
    dma_data[1]   = 32'h1000;
    tick();
    chk("t2_first_valid", 1, mage_valid[1], 1);
    chk("t2_first_data", 1, mage_data[1], 32'h1000);
    for (int k = 1; k < 100; k++) begin
      dma_data[1] = DW'(32'h1000 + k);
      tick();
      chk("t2_count", 1, count[1], 1);
      chk("t2_data", 1, mage_data[1], 32'h1000 + k);
    end
    dma_valid[1] = 1'b0;
    tick();
    chk("t2_drained", 1, count[1], 0);
    mage_ready[1] = 1'b0;

    // Full boundary on ch1
    for (int i = 0; i < 8; i++) begin
      dma_valid[1] = 1'b1;
      dma_data[1]  = DW'(32'hB0 + i);
      tick();
    end
    dma_data[1] = 32'hBB;
    tick();
    chk("t3_stalled", 1, dma_ready[1], 0);
    mage_ready[1] = 1'b1;
    tick();
    chk("t3_pop_no_push", 1, count[1], 7);
    chk("t3_ready_back", 1, dma_ready[1], 1);
    mage_ready[1] = 1'b0;
    tick();
    chk("t3_refill", 1, count[1], 8);
    dma_valid[1] = 1'b0;

    // Flush ch2 with a simultaneous push, ch3 as bystander
    for (int i = 0; i < 5; i++) begin
      dma_valid[2] = 1'b1;
      dma_data[2]  = DW'(32'h20 + i);
      dma_valid[3] = (i < 3);
      dma_data[3]  = DW'(32'hC0 + i);
      tick();
    end
    dma_valid[3] = 1'b0;
    dma_data[2]  = 32'h55;
    flush[2]     = 1'b1;
    tick();
    flush[2] = 1'b0; dma_valid[2] = 1'b0;
    chk("t4_flushed", 2, count[2], 0);
    chk("t4_valid", 2, mage_valid[2], 0);
    chk("t4_bystander", 3, count[3], 3);
    chk("t4_bystander_data", 3, mage_data[3], 32'hC0);
    tick();
    chk("t4_no55", 2, mage_valid[2], 0);

    // Overflow on ch0
    for (int i = 0; i < 8; i++) begin
      dma_valid[0] = 1'b1;
      dma_data[0]  = DW'(32'h30 + i);
      tick();
    end
    dma_data[0] = 32'h99;
    for (int s = 1; s <= 18; s++) begin
      tick();
      chk("t5_ovf", 0, overflow[0], (s >= 16));
    end
    dma_valid[0] = 1'b0;
    tick();
    chk("t5_sticky", 0, overflow[0], 1);
    clr_status[0] = 1'b1;
    tick();
    clr_status[0] = 1'b0;
    chk("t5_cleared", 0, overflow[0], 0);

    // Randomized traffic; DMA holds its word while stalled
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (!held[c]) begin
          dma_valid[c] = ($urandom_range(0, 3) != 0);
          dma_data[c]  = $urandom;
        end
        mage_ready[c] = (cyc < 300) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
        flush[c]      = ($urandom_range(0, 31) == 0);
        clr_status[c] = ($urandom_range(0, 15) == 0);
      end
      tick();
    end
    flush = '0; clr_status = '0; mage_ready = '0;

    // Asynchronous reset mid-burst
    for (int c = 0; c < N_CH; c++) if (!held[c]) dma_valid[c] = 1'b0;
    dma_valid[0] = 1'b1;
    dma_data[0]  = held[0] ? dma_data[0] : 32'hE0;
    tick();
    tick();
    #2;
    dma_valid = '0;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    @(negedge clk);
    rst_n = 1'b1;
    dma_valid[0] = 1'b1;
    dma_data[0]  = 32'hD0;
    tick();
    dma_valid[0] = 1'b0;
    chk("t6_valid", 0, mage_valid[0], 1);
    chk("t6_data", 0, mage_data[0], 32'hD0);
    tick();
    chk("t6_count", 0, count[0], 1);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mage_stream_fifo_bridge.md
# mage_stream_fifo_bridge

- Per-channel elastic buffer between the system DMA write channels and the Mage hardware-FIFO stream inputs.
- Accepts `N_DMA_CH` independent valid/ready word streams from the DMA and queues each one in its own FIFO.
- Presents each queue to Mage as a valid/ready stream and reports per-channel occupancy and status.
- Decouples DMA burst timing from CGRA consumption and breaks all combinational ready paths between the two.

## Interface
Parameters:
- `N_CH`, default `N_DMA_CH` (from `stream_intf_pkg`): number of independent channels.
- `DATA_W`, default 32: word width.
- `DEPTH`, default 8: entries per channel; must be a power of two and ≥ 2.
- `AF_THRESH`, default `DEPTH-2`: almost-full threshold in entries.

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `rst_n_i`  in  1  asynchronous reset, active-low.
- `dma_valid_i`  in  [N_CH]  DMA word valid, per channel.
- `dma_data_i`  in  [N_CH][DATA_W]  DMA word.
- `dma_ready_o`  out  [N_CH]  channel can accept a word.
- `mage_valid_o`  out  [N_CH]  head word valid toward Mage.
- `mage_data_o`  out  [N_CH][DATA_W]  head word.
- `mage_ready_i`  in  [N_CH]  Mage consumes the head word.
- `flush_i`  in  [N_CH]  synchronous per-channel clear.
- `count_o`  out  [N_CH][$clog2(DEPTH+1)]  current occupancy.
- `almost_full_o`  out  [N_CH]  high when `count_o ≥ AF_THRESH`.
- `overflow_o`  out  [N_CH]  sticky flag: DMA presented valid while ready was low for ≥ `OVF_CYC` consecutive cycles.
- `clr_status_i`  in  [N_CH]  clears `overflow_o`.

## Operation
- Handshakes:
  - Push when `dma_valid_i & dma_ready_o`.
  - Pop when `mage_valid_o & mage_ready_i`.
  - Data must be held stable by the sender while valid and not ready. This is a bench assertion, not checked in RTL.
- Storage per channel:
  - Register array of `DEPTH` words.
  - Write and read pointers of `$clog2(DEPTH)` bits; wrap naturally modulo `DEPTH`.
  - Occupancy counter of `$clog2(DEPTH+1)` bits.
  - The counter is authoritative for full/empty.
- Counter update, in priority order:
  - flush → 0;
  - push & pop → unchanged;
  - push → +1;
  - pop → −1.
- Derived flags:
  - `dma_ready_o = (count != DEPTH)`, driven from the registered count only, with no dependency on `mage_ready_i`.
  - `mage_valid_o = (count != 0)`.
  - `mage_data_o = mem[rd_ptr]`.
- Full boundary: at `count == DEPTH` a pop does not enable a same-cycle push. Ready rises the cycle after the pop.
- Empty boundary: no fall-through. A word pushed in cycle N is visible on `mage_valid_o` in cycle N+1.
- Flush:
  - Pointers and count go to 0 on the next edge.
  - A push or pop in the flush cycle is discarded; the DMA handshake still completes, so the word is dropped.
  - `overflow_o` is unaffected by flush.
- Overflow:
  - A per-channel stall counter increments while `dma_valid_i & !dma_ready_o`, saturates at `OVF_CYC`, and clears otherwise.
  - Reaching `OVF_CYC` sets `overflow_o`.
  - `clr_status_i` clears the flag; if set and clear occur together, set wins.
- Channel isolation: activity on any channel, including flush, never affects another channel's state or outputs.

## Timing
- Reset values:
  - all `count_o` = 0;
  - `mage_valid_o` = 0;
  - `dma_ready_o` = all ones (asserted during and after reset);
  - `almost_full_o` = 0;
  - `overflow_o` = 0;
  - `mage_data_o` = 0;
  - pointers = 0.
- Memory array contents are not reset; `mage_data_o` is gated to 0 while empty.
- Latency: DMA→Mage is 1 cycle minimum.
- Throughput: 1 word/cycle/channel sustained when neither side stalls and count is in 1..DEPTH-1.
- Flags: `count_o`, `almost_full_o`, `dma_ready_o` and `mage_valid_o` all update in the cycle after the causing handshake.
- Reset mid-operation: assertion of `rst_n_i` immediately forces the reset values above, with no dependency on the clock. Buffered words are lost.

## Structure
- Shared package `stream_intf_pkg` holds:
  - `N_DMA_CH`;
  - `STREAM_DATA_W`;
  - `STREAM_FIFO_DEPTH`;
  - `OVF_CYC` (default 16).
- Single-channel sub-module `mage_stream_fifo` contains storage, pointers, counter, flags and overflow monitor.
- The top module instantiates `mage_stream_fifo` N_CH times in a generate loop and contains no logic of its own.

## Test plan
- **Reset and basic transfer:** hold `mage_ready_i=0`, push 0xA0..0xA7 on ch0.
  - `dma_ready_o[0]` drops after the 8th word.
  - `count_o[0]=8`, `almost_full_o[0]` high from count 6.
  - Then `mage_ready_i=1` → data out 0xA0..0xA7 in order, one per cycle.
- **Streaming:** both sides always ready, 100 words.
  - First output 1 cycle after first push.
  - 100 consecutive cycles with valid.
  - Count stays at 1.
- **Full boundary:** with ch1 full, pop one word in cycle N while DMA holds valid.
  - No push in N.
  - `dma_ready_o[1]` high in N+1, push accepted, count returns to 8.
- **Flush:** ch2 at count 5; assert `flush_i[2]` with a simultaneous push of 0x55.
  - Next cycle count=0, `mage_valid_o[2]=0`, 0x55 never appears.
  - ch3 contents are untouched.
- **Overflow:** ch0 full, `dma_valid_i` held high for 16 cycles.
  - `overflow_o[0]` rises after the 16th stall cycle and stays high.
  - `clr_status_i` pulse clears it.
- **Asynchronous reset:** assert `rst_n_i` low mid-burst between clock edges.
  - Outputs take their reset values immediately.
  - After release, the first new word is output correctly.
